// File: rtl/mem_pkg.sv
// Shared types for the unified-memory arbiter: access sizes, FSM states and burst length helper.
package mem_pkg;

    localparam logic [31:0] MEM_BASE = 32'h8002_0000;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WORD  = 2'd1,
        SZ_4WORD = 2'd2,
        SZ_8WORD = 2'd3
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    function automatic int unsigned beats_of(input access_size_t sz);
        case (sz)
            SZ_4WORD: beats_of = 4;
            SZ_8WORD: beats_of = 8;
            default:  beats_of = 1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker between fetch and load/store; the pointer moves only on a taken grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_fetch,
    input  logic i_req_lsu,
    input  logic i_take,
    output logic o_gnt_fetch,
    output logic o_gnt_lsu
);

    logic r_last_fetch;
    logic w_gnt_lsu;

    // On a tie the requester that was not granted last wins; reset favours the LSU first.
    assign w_gnt_lsu   = i_req_lsu & (~i_req_fetch | r_last_fetch);
    assign o_gnt_lsu   = w_gnt_lsu;
    assign o_gnt_fetch = i_req_fetch & ~w_gnt_lsu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_fetch <= 1'b1;
        end else if (i_take && (o_gnt_fetch || w_gnt_lsu)) begin
            r_last_fetch <= o_gnt_fetch;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (single/burst reads) and
// load/store (byte/word), sequencing enable/rd_wr/size and returning data with registered handshakes.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  access_size_t      i_size,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  access_size_t      d_size,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_enable,
    output logic              mem_rd_wr,
    output access_size_t      mem_access_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_busy,
    output arb_state_t        o_dbg_state
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_take;
    logic              w_gnt_fetch;
    logic              w_gnt_lsu;
    access_size_t      w_i_size;
    access_size_t      w_d_size;

    logic              r_owner_lsu;
    logic [BEAT_W-1:0] r_beats;
    logic              r_pend;
    logic              r_mem_enable;
    logic              r_mem_rd_wr;
    access_size_t      r_mem_size;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_i_rvalid;
    logic              r_i_ack;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_ack;

    assign w_i_size = (i_size == SZ_BYTE) ? SZ_WORD : i_size;
    assign w_d_size = (d_size == SZ_BYTE) ? SZ_BYTE : SZ_WORD;

    rr_arb2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_fetch (i_req),
        .i_req_lsu   (d_req),
        .i_take      (w_take),
        .o_gnt_fetch (w_gnt_fetch),
        .o_gnt_lsu   (w_gnt_lsu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // The cycle an ack is on the wire is skipped so every grant is separated by an idle cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((i_req || d_req) && !r_i_ack && !r_d_ack) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_beats == BEAT_W'(1)) w_state_nxt = RESP;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_lsu  <= 1'b0;
            r_beats      <= '0;
            r_pend       <= 1'b0;
            r_mem_enable <= 1'b0;
            r_mem_rd_wr  <= 1'b1;
            r_mem_size   <= SZ_BYTE;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_i_rdata    <= '0;
            r_i_rvalid   <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_rdata    <= '0;
            r_d_ack      <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            // Memory read data is registered: it appears the cycle after an enabled read.
            r_pend     <= r_mem_enable & r_mem_rd_wr;
            if (r_pend) begin
                if (r_owner_lsu) begin
                    r_d_rdata <= (r_mem_size == SZ_BYTE) ?
                                 {{(DATA_W-8){1'b0}}, mem_data_out[7:0]} : mem_data_out;
                end else begin
                    r_i_rdata  <= mem_data_out;
                    r_i_rvalid <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_owner_lsu  <= w_gnt_lsu;
                        r_mem_enable <= 1'b1;
                        if (w_gnt_lsu) begin
                            r_mem_addr  <= d_addr;
                            r_mem_rd_wr <= ~d_we;
                            r_mem_size  <= w_d_size;
                            r_mem_wdata <= d_wdata;
                            r_beats     <= BEAT_W'(1);
                        end else begin
                            r_mem_addr  <= i_addr;
                            r_mem_rd_wr <= 1'b1;
                            r_mem_size  <= w_i_size;
                            r_beats     <= BEAT_W'(beats_of(w_i_size));
                        end
                    end
                end
                ISSUE: begin
                    r_beats <= r_beats - BEAT_W'(1);
                    if (r_beats == BEAT_W'(1)) begin
                        r_mem_enable <= 1'b0;
                        r_mem_rd_wr  <= 1'b1;
                    end
                end
                RESP: begin
                    if (r_owner_lsu) r_d_ack <= 1'b1;
                    else             r_i_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign i_rdata         = r_i_rdata;
    assign i_rvalid        = r_i_rvalid;
    assign i_ack           = r_i_ack;
    assign d_rdata         = r_d_rdata;
    assign d_ack           = r_d_ack;
    assign mem_enable      = r_mem_enable;
    assign mem_rd_wr       = r_mem_rd_wr;
    assign mem_access_size = r_mem_size;
    assign mem_addr        = r_mem_addr;
    assign mem_data_in     = r_mem_wdata;
    assign o_dbg_state     = r_state;

    a_busy_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_state == IDLE && !r_mem_enable && mem_busy));

endmodule
